// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/optional parity/stop framing with
// 2-of-3 majority voting around the bit centre and per-frame error tracking.
module uart_rx #(
  parameter int Data_width = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [Data_width-1:0] RX_P_DATA,
  output logic                  RX_data_valid
);

  localparam int BW = (Data_width > 1) ? $clog2(Data_width) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(Data_width - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [5:0]            edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [Data_width-1:0] shift_q, shift_d;
  logic [Data_width-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [2:0]            samp_q, samp_d;
  logic                  err_q, err_d;
  logic [5:0]            presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;

  logic [5:0] half;
  logic       last_edge;
  logic       bit_val;
  logic       par_exp;
  logic [2:0] samp_hit;

  // Frame configuration is frozen at IDLE exit so mid-frame changes are ignored.
  assign half      = presc_q >> 1;
  assign last_edge = (edge_cnt_q == presc_q - 6'd1);
  assign bit_val   = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign par_exp   = par_typ_q ? ~^shift_q : ^shift_q;

  for (genvar gi = 0; gi < 3; gi++) begin : g_samp
    assign samp_hit[gi] = (edge_cnt_q == half - 6'd1 + 6'(gi));
  end

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    samp_d     = samp_q;
    err_d      = err_q;
    presc_d    = presc_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;

    if (state_q != IDLE) begin
      edge_cnt_d = last_edge ? 6'd0 : edge_cnt_q + 6'd1;
      for (int i = 0; i < 3; i++) begin
        if (samp_hit[i]) samp_d[i] = RX_IN;
      end
    end

    case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          // This edge counts as edge 0 of the start bit.
          state_d    = START;
          edge_cnt_d = 6'd1;
          bit_cnt_d  = '0;
          err_d      = 1'b0;
          presc_d    = prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
        end
      end
      START: begin
        if (last_edge) state_d = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (last_edge) begin
          shift_d[bit_cnt_q] = bit_val;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (last_edge) begin
          if (bit_val != par_exp) err_d = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (edge_cnt_q == half + 6'd2) begin
          err_d = err_q | ~bit_val;
          if (bit_val && !err_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
        if (last_edge) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      samp_q     <= '0;
      err_q      <= 1'b0;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      samp_q     <= samp_d;
      err_q      <= err_d;
      presc_q    <= presc_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
    end
  end

  assign RX_P_DATA     = data_q;
  assign RX_data_valid = valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model of expected pulses and
// held data, checked every cycle, plus directed frames with literal results.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] RX_P_DATA;
  logic       RX_data_valid;

  always #5 CLK = ~CLK;

  uart_rx #(.Data_width(8)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .RX_IN         (RX_IN),
    .prescale      (prescale),
    .PAR_EN        (PAR_EN),
    .PAR_TYP       (PAR_TYP),
    .RX_P_DATA     (RX_P_DATA),
    .RX_data_valid (RX_data_valid)
  );

  typedef struct {
    longint     t;
    logic [7:0] d;
  } ev_t;

  int         errors = 0;
  int         checks = 0;
  longint     cyc = 0;
  int         pulses = 0;
  longint     last_pulse = -1;
  ev_t        exp_q[$];
  logic [7:0] model_data = 8'h00;

  always @(posedge CLK) cyc <= cyc + 1;

  // Per-cycle comparison: a pulse is due exactly at its predicted cycle.
  always @(negedge CLK) begin
    logic exp_v;
    ev_t  e;
    exp_v = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
      e = exp_q.pop_front();
      exp_v = 1'b1;
      model_data = e.d;
    end
    if (!RST) model_data = 8'h00;
    checks++;
    if (RX_data_valid !== exp_v) begin
      errors++;
      $display("FAIL valid@%0d: got %b expected %b", cyc, RX_data_valid, exp_v);
    end
    checks++;
    if (RX_P_DATA !== model_data) begin
      errors++;
      $display("FAIL data@%0d: got %02h expected %02h", cyc, RX_P_DATA, model_data);
    end
    if (RX_data_valid === 1'b1) begin
      pulses++;
      last_pulse = cyc;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic drive_bit(input logic b, input int p, input bit flip);
    int fpos;
    fpos = flip ? (p / 2 - 1 + int'($urandom_range(0, 2))) : -1;
    for (int i = 0; i < p; i++) begin
      RX_IN = (i == fpos) ? ~b : b;
      @(negedge CLK);
    end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic glitch(input int p, input int g);
    prescale = 6'(p);
    RX_IN = 1'b0;
    repeat (g) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (p - g) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input bit pe, input bit pt,
                            input bit bad_par, input bit bad_stop, input bit flips,
                            output longint t0);
    logic pbit;
    ev_t  e;
    prescale = 6'(p);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    t0 = cyc + 1;
    pbit = (pt ? ~^d : ^d) ^ bad_par;
    if (!(pe && bad_par) && !bad_stop) begin
      e.t = t0 + longint'((9 + int'(pe)) * p + p / 2 + 2);
      e.d = d;
      exp_q.push_back(e);
    end
    $display("frame d=%02h p=%0d pe=%0d pt=%0d bad_par=%0d bad_stop=%0d t0=%0d",
             d, p, pe, pt, bad_par, bad_stop, t0);
    drive_bit(1'b0, p, flips && $urandom_range(0, 1) == 1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p, flips && $urandom_range(0, 1) == 1);
    if (pe) drive_bit(pbit, p, flips && $urandom_range(0, 1) == 1);
    drive_bit(~bad_stop, p, flips && $urandom_range(0, 1) == 1);
  endtask

  initial begin
    longint t0;
    int     pc;
    int     p;
    bit     pe;
    repeat (3) @(negedge CLK);
    chk("reset_data", RX_P_DATA, 0);
    chk("reset_valid", RX_data_valid, 0);
    RST = 1'b1;
    idle(20);
    chk("idle_after_reset", RX_P_DATA, 0);

    pc = pulses;
    send_frame(8'hAB, 8, 0, 0, 0, 0, 0, t0);
    chk("p8_AB_data", RX_P_DATA, 8'hAB);
    chk("p8_AB_pulses", pulses - pc, 1);
    chk("p8_latency", last_pulse - t0, 78);
    idle(5);

    pc = pulses;
    send_frame(8'hCD, 16, 1, 0, 0, 0, 0, t0);
    chk("p16_CD_data", RX_P_DATA, 8'hCD);
    chk("p16_latency", last_pulse - t0, 170);
    send_frame(8'hCD, 16, 1, 0, 1, 0, 0, t0);
    chk("p16_badpar_data", RX_P_DATA, 8'hCD);
    chk("p16_pulses", pulses - pc, 1);
    idle(5);

    pc = pulses;
    send_frame(8'hEF, 32, 1, 1, 0, 0, 0, t0);
    chk("p32_EF_data", RX_P_DATA, 8'hEF);
    chk("p32_latency", last_pulse - t0, 338);
    send_frame(8'h55, 8, 0, 0, 0, 1, 0, t0);
    idle(4);
    chk("badstop_data", RX_P_DATA, 8'hEF);
    chk("p32_badstop_pulses", pulses - pc, 1);

    pc = pulses;
    glitch(16, 3);
    chk("glitch_pulses", pulses - pc, 0);
    send_frame(8'h3C, 16, 0, 0, 0, 0, 0, t0);
    chk("after_glitch_data", RX_P_DATA, 8'h3C);
    idle(3);

    pc = pulses;
    send_frame(8'h12, 8, 0, 0, 0, 0, 0, t0);
    chk("b2b_first", RX_P_DATA, 8'h12);
    send_frame(8'h34, 8, 0, 0, 0, 0, 0, t0);
    chk("b2b_second", RX_P_DATA, 8'h34);
    chk("b2b_pulses", pulses - pc, 2);
    idle(2);

    for (int n = 0; n < 40; n++) begin
      p  = 8 << $urandom_range(0, 2);
      pe = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) begin
        glitch(p, int'($urandom_range(1, 3)));
      end else begin
        send_frame(8'($urandom), p, pe, $urandom_range(0, 1) == 1,
                   pe && $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 1) == 1, t0);
      end
      idle(int'($urandom_range(0, 3)));
    end

    send_frame(8'h5A, 8, 0, 0, 0, 0, 0, t0);
    idle(4);
    chk("pre_reset_data", RX_P_DATA, 8'h5A);
    pc = pulses;
    prescale = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (30) @(negedge CLK);
    @(posedge CLK);
    #3;
    RST = 1'b0;
    #1;
    chk("async_reset_data", RX_P_DATA, 0);
    chk("async_reset_valid", RX_data_valid, 0);
    @(negedge CLK);
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    idle(150);
    chk("aborted_pulses", pulses - pc, 0);
    chk("aborted_data", RX_P_DATA, 0);
    send_frame(8'h99, 8, 1, 1, 0, 0, 0, t0);
    chk("recover_data", RX_P_DATA, 8'h99);
    idle(10);
    chk("pending_events", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter Data_width, default 8, the number of data bits per frame.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock, oversampling at prescale times the bit rate; all logic on the rising edge.
REQ-003 SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port RX_IN, input, 1 bit: serial line, idle high.
REQ-005 SHALL have port prescale, input, 6 bits: CLK cycles per bit; 8, 16 and 32 supported; other values undefined.
REQ-006 SHALL have port PAR_EN, input, 1 bit: 1 = a parity bit follows the data bits.
REQ-007 SHALL have port PAR_TYP, input, 1 bit: 0 = even parity, 1 = odd parity.
REQ-008 SHALL have port RX_P_DATA, output, Data_width bits: last correctly received data word.
REQ-009 SHALL have port RX_data_valid, output, 1 bit: one-cycle pulse when RX_P_DATA is updated.

Function
REQ-010 SHALL receive frames as: start bit (0), Data_width data bits LSB first, an optional parity bit, then a stop bit (1); each bit lasts prescale CLK cycles.
REQ-011 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL keep an edge counter (0..prescale-1, wraps at prescale-1) and a bit counter (0..Data_width-1).
REQ-013 SHALL leave IDLE on the first rising edge where RX_IN=0; that cycle is edge 0 of the start bit, and the FSM enters START.
REQ-014 SHALL sample RX_IN at edge counts prescale/2-1, prescale/2 and prescale/2+1 of every bit; the bit value is the majority (2 of 3).
REQ-015 START: if the sampled start bit is 1 (glitch), the FSM SHALL return to IDLE at the end of the bit period without reporting anything.
REQ-016 START: if the sampled start bit is 0, the FSM SHALL enter DATA at the bit boundary.
REQ-017 DATA SHALL shift each sampled bit into a shift register at bit position bit_cnt.
REQ-018 After bit Data_width-1, DATA SHALL go to PARITY if PAR_EN=1, else to STOP.
REQ-019 PARITY SHALL compare the sampled bit with the expected value: ^data when PAR_TYP=0, ~^data when PAR_TYP=1.
REQ-020 On a parity mismatch the frame SHALL be marked errored; the FSM then proceeds to STOP.
REQ-021 STOP: the sampled stop bit must be 1, else the frame is errored (framing error).
REQ-022 STOP: on the cycle at edge count prescale/2+2, a frame with no error SHALL load RX_P_DATA and pulse RX_data_valid high for exactly one cycle.
REQ-023 STOP: for an errored frame, RX_P_DATA SHALL be held and RX_data_valid SHALL stay 0.
REQ-024 At edge count prescale-1 of the stop bit, the FSM SHALL return to IDLE, so a start bit immediately following is accepted (back-to-back frames).
REQ-025 PAR_EN, PAR_TYP and prescale SHALL be treated as static during a frame; changes take effect at the next IDLE exit.
REQ-026 RX_P_DATA SHALL hold its value between frames; it is not cleared on errors.
REQ-027 Latency SHALL be fixed: valid rises (1+Data_width+PAR_EN)*prescale + prescale/2+2 cycles after edge 0 of the start bit.

Reset
REQ-028 While RST=0, regardless of CLK, the design SHALL force: FSM to IDLE, all counters and the shift register to 0, RX_P_DATA = 0, RX_data_valid = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no valid pulse; after release, reception restarts at the next falling edge of RX_IN.
REQ-030 After reset release with RX_IN=1, outputs SHALL stay at their reset values until a complete valid frame is received.

Verification
REQ-031 prescale=8, PAR_EN=0, frame carrying 0xAB -> one valid pulse during the stop bit; RX_P_DATA=0xAB.
REQ-032 prescale=16, PAR_EN=1, PAR_TYP=0, data 0xCD with parity bit 1 -> RX_P_DATA=0xCD, one valid pulse; the same frame with parity 0 -> no pulse, RX_P_DATA unchanged.
REQ-033 prescale=32, PAR_EN=1, PAR_TYP=1, data 0xEF with parity bit 0 -> RX_P_DATA=0xEF, one valid pulse.
REQ-034 prescale=8, 0x55 with stop bit 0 -> no valid pulse; RX_P_DATA keeps its previous value.
REQ-035 prescale=16, RX_IN low pulse of 3 cycles then high -> returns to IDLE, no pulse; a following 0x3C frame is received correctly.
REQ-036 prescale=8, two back-to-back frames 0x12 then 0x34 with no idle gap -> two pulses, RX_P_DATA=0x12 then 0x34; RST pulsed low mid-frame -> outputs 0, no pulse.
